// File: rtl/nr_div_pkg.sv
// Shared types and elaboration-time helpers for the Newton-Raphson significand divider.
// Widths are functions of MW so the divider and its multiplier agree on every parameterisation.
package nr_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_NR_A,
    S_NR_X,
    S_QMUL,
    S_REM,
    S_CORR
  } state_t;

  // Reciprocal working width: 1 integer bit, MW+4 fraction bits.
  function automatic int xw_of(input int mw);
    return mw + 5;
  endfunction

  // Quotient width: 2 integer bits, MW+1 fraction bits.
  function automatic int qw_of(input int mw);
    return mw + 3;
  endfunction

  function automatic int lat_of(input int iter, input int mul_lat);
    return 1 + 2 * iter * (mul_lat + 1) + 2 * (mul_lat + 1) + 1;
  endfunction

  // round(2^(T+1) / (1 + (i+0.5)/2^T)) in integer form; the odd denominator rules out ties.
  function automatic int seed_entry(input int tbl_bits, input int idx);
    int num;
    int den;
    num = 1 << (2 * tbl_bits + 2);
    den = (1 << (tbl_bits + 1)) + 2 * idx + 1;
    return (2 * num + den) / (2 * den);
  endfunction

endpackage

// File: rtl/nr_div_seq_if.sv
// Operand/result handshake between the FPU unpack stage, the divider and the rounder.
interface nr_div_seq_if #(
  parameter int MW = 53
);
  logic          start;
  logic [MW-1:0] fa;
  logic [MW-1:0] fb;
  logic          db;
  logic          busy;
  logic          done;
  logic          inv;
  logic [MW+3:0] fq;

  modport master (output start, fa, fb, db, input busy, done, inv, fq);
  modport slave  (input start, fa, fb, db, output busy, done, inv, fq);
endinterface

// File: rtl/nr_mul_pipe.sv
// Unsigned W x W multiplier with LAT output register stages (LAT=0 is purely combinational).
module nr_mul_pipe #(
  parameter int W   = 58,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  if (LAT == 0) begin : g_comb
    assign p = prod;
  end else begin : g_pipe
    logic [2*W-1:0] stg [LAT];

    // NOTE: pure datapath pipeline, no reset; the controller never samples it before it has filled.
    always_ff @(posedge clk) begin
      stg[0] <= prod;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end

    assign p = stg[LAT-1];
  end

endmodule

// File: rtl/nr_div_seq.sv
// Iterative Newton-Raphson significand divider: table seed, ITER refinements, q = fa*x,
// then an exact remainder check that nudges q by one ulp and yields the sticky bit.
module nr_div_seq
  import nr_div_pkg::*;
#(
  parameter int MW       = 53,
  parameter int TBL_BITS = 8,
  parameter int ITER_DP  = 3,
  parameter int ITER_SP  = 2,
  parameter int SP_FRAC  = 25,
  parameter int MUL_LAT  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  nr_div_seq_if.slave  bus
);

  localparam int XW    = xw_of(MW);
  localparam int QW    = qw_of(MW);
  localparam int PW    = 2 * XW;
  localparam int RW    = PW + 1;
  localparam int SP_SH = MW + 1 - SP_FRAC;
  localparam int CW    = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  state_t               state_r;
  logic [MW-1:0]        fa_r, fb_r;
  logic                 db_r;
  logic [XW-1:0]        x_r, a_r;
  logic [QW-1:0]        q_r;
  logic signed [RW-1:0] r_r;
  logic [7:0]           it_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r, done_r, inv_r;
  logic [MW+3:0]        fq_r;

  // Seed ROM holds the entry minus its always-set leading one.
  logic [TBL_BITS-1:0] seed_rom [2**TBL_BITS];
  for (genvar g = 0; g < 2**TBL_BITS; g++) begin : g_seed
    assign seed_rom[g] = TBL_BITS'(seed_entry(TBL_BITS, g) - (1 << TBL_BITS));
  end

  logic [XW-1:0] seed_x0;
  assign seed_x0 = XW'({1'b1, seed_rom[fb_r[MW-2 -: TBL_BITS]]}) << (XW - TBL_BITS - 2);

  logic [XW-1:0] mul_a, mul_b;
  logic [PW-1:0] mul_p;

  nr_mul_pipe #(.W(XW), .LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_r)
      S_NR_A:  begin mul_a = XW'(fb_r); mul_b = x_r;         end
      S_NR_X:  begin mul_a = x_r;       mul_b = a_r;         end
      S_QMUL:  begin mul_a = XW'(fa_r); mul_b = x_r;         end
      S_REM:   begin mul_a = XW'(q_r);  mul_b = XW'(fb_r);   end
      default: ;
    endcase
  end

  // Product scalings: fb*x and fa*x carry MW-1+XW-1 fraction bits, x*A carries 2*(XW-1).
  logic [XW-1:0]        a_next, x_next, bx;
  logic [QW-1:0]        q_raw, q_next;
  logic [RW-1:0]        fa_sh;
  logic signed [RW-1:0] r_next;

  assign bx     = mul_p[MW-1 +: XW];
  assign a_next = -bx;
  assign x_next = mul_p[XW-1 +: XW];
  assign q_raw  = mul_p[XW-3 +: QW];
  assign q_next = db_r ? q_raw : (q_raw & {{(QW-SP_SH){1'b1}}, {SP_SH{1'b0}}});
  assign fa_sh  = RW'(fa_r) << (MW + 1);
  assign r_next = $signed(fa_sh) - $signed({1'b0, mul_p});

  // Remainder is scaled by 2^(2*MW), so one quotient ulp of remainder equals fb (DP).
  logic signed [RW-1:0] r_step, r_fix;
  logic [QW-1:0]        q_step, q_fix;

  always_comb begin
    r_step = db_r ? RW'(fb_r) : (RW'(fb_r) << SP_SH);
    q_step = db_r ? QW'(1)    : (QW'(1) << SP_SH);
    q_fix  = q_r;
    r_fix  = r_r;
    if (r_r[RW-1]) begin
      q_fix = q_r - q_step;
      r_fix = r_r + r_step;
    end else if (r_r >= r_step) begin
      q_fix = q_r + q_step;
      r_fix = r_r - r_step;
    end
  end

  logic mul_last, iter_last;
  assign mul_last  = (cnt_r == CW'(MUL_LAT));
  assign iter_last = (it_r == 8'(db_r ? ITER_DP - 1 : ITER_SP - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      fa_r    <= '0;
      fb_r    <= '0;
      db_r    <= 1'b0;
      x_r     <= '0;
      a_r     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      it_r    <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      inv_r   <= 1'b0;
      fq_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: if (bus.start) begin
          fa_r    <= bus.fa;
          fb_r    <= bus.fb;
          db_r    <= bus.db;
          busy_r  <= 1'b1;
          state_r <= S_SEED;
        end
        S_SEED: if (!fb_r[MW-1]) begin
          done_r  <= 1'b1;
          inv_r   <= 1'b1;
          fq_r    <= '1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end else begin
          x_r     <= seed_x0;
          it_r    <= '0;
          cnt_r   <= '0;
          state_r <= S_NR_A;
        end
        S_NR_A: if (mul_last) begin
          a_r     <= a_next;
          cnt_r   <= '0;
          state_r <= S_NR_X;
        end else cnt_r <= cnt_r + 1'b1;
        S_NR_X: if (mul_last) begin
          x_r   <= x_next;
          cnt_r <= '0;
          if (iter_last) state_r <= S_QMUL;
          else begin
            it_r    <= it_r + 1'b1;
            state_r <= S_NR_A;
          end
        end else cnt_r <= cnt_r + 1'b1;
        S_QMUL: if (mul_last) begin
          q_r     <= q_next;
          cnt_r   <= '0;
          state_r <= S_REM;
        end else cnt_r <= cnt_r + 1'b1;
        S_REM: if (mul_last) begin
          r_r     <= r_next;
          cnt_r   <= '0;
          state_r <= S_CORR;
        end else cnt_r <= cnt_r + 1'b1;
        S_CORR: begin
          fq_r    <= {q_fix, r_fix != '0};
          inv_r   <= 1'b0;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.inv  = inv_r;
  assign bus.fq   = fq_r;

endmodule

// File: tb/tb_nr_div_seq.sv
// Bench for nr_div_seq: directed handshake/latency cases plus random operands against
// an exact long-division reference (floor quotient and sticky).
module tb_nr_div_seq;

  localparam int MW      = 53;
  localparam int SP_FRAC = 25;
  localparam int FW      = MW + 4;
  localparam int L_DP    = 18;
  localparam int L_SP    = 14;

  localparam logic [MW-1:0] ONE     = 53'h10000000000000;
  localparam logic [MW-1:0] ONE_P5  = 53'h18000000000000;
  localparam logic [FW-1:0] Q_15_10 = 57'h0C0000000000000;
  localparam logic [FW-1:0] Q_10_15 = 57'h055555555555555;
  localparam logic [FW-1:0] Q_SP    = 57'h055555540000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  nr_div_seq_if #(.MW(MW)) bus ();

  nr_div_seq #(
    .MW(MW), .TBL_BITS(8), .ITER_DP(3), .ITER_SP(2), .SP_FRAC(SP_FRAC), .MUL_LAT(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Exact reference: long division at the kept precision, sticky = nonzero remainder.
  function automatic logic [FW-1:0] ref_fq(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                           input logic d);
    logic [2*MW+8:0] num, den, q, rm;
    if (!b[MW-1]) return '1;
    num = '0;
    num[MW-1:0] = a;
    den = '0;
    den[MW-1:0] = b;
    num = num << (d ? MW + 1 : SP_FRAC);
    q  = num / den;
    rm = num % den;
    if (!d) q = q << (MW + 1 - SP_FRAC);
    return {q[MW+2:0], rm != '0};
  endfunction

  function automatic logic [MW-1:0] rnd_sig();
    return MW'({$urandom(), $urandom()});
  endfunction

  // Present operands with start for one edge, then scramble the operand lines.
  task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic d);
    bus.fa    = a;
    bus.fb    = b;
    bus.db    = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.fa    = rnd_sig();
    bus.fb    = rnd_sig() >> 1;
    bus.db    = ~d;
  endtask

  // Edges from accept to the done sample; busy_bad flags busy low before done or high at done.
  task automatic wait_done(output int lat, output bit busy_bad);
    lat = 0;
    busy_bad = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done && !bus.busy) busy_bad = 1'b1;
    end while (!bus.done && lat < 100);
    if (bus.busy) busy_bad = 1'b1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.fa = '0;
    bus.fb = '0;
    bus.db = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.inv !== 1'b0) begin failures++; $display("FAIL reset inv: got %b want 0", bus.inv); end
    checks++; if (bus.fq !== '0) begin failures++; $display("FAIL reset fq: got %h want 0", bus.fq); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL idle after reset: busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_dp();
    int lat;
    bit bb;
    launch(ONE_P5, ONE, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL dp accept busy: got %b want 1", bus.busy); end
    wait_done(lat, bb);
    checks++; if (lat != L_DP) begin failures++; $display("FAIL dp 1.5/1.0 latency: got %0d want %0d", lat, L_DP); end
    checks++; if (bb) begin failures++; $display("FAIL dp 1.5/1.0 busy window: got bad=1 want 0"); end
    checks++; if (bus.fq !== Q_15_10) begin failures++; $display("FAIL dp 1.5/1.0 fq: got %h want %h", bus.fq, Q_15_10); end
    checks++; if (bus.inv !== 1'b0) begin failures++; $display("FAIL dp 1.5/1.0 inv: got %b want 0", bus.inv); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dp done width: got %b want 0", bus.done); end
    launch(ONE, ONE_P5, 1'b1);
    wait_done(lat, bb);
    checks++; if (lat != L_DP) begin failures++; $display("FAIL dp 1.0/1.5 latency: got %0d want %0d", lat, L_DP); end
    checks++; if (bus.fq !== Q_10_15) begin failures++; $display("FAIL dp 1.0/1.5 fq: got %h want %h", bus.fq, Q_10_15); end
  endtask

  task automatic test_sp();
    int lat;
    bit bb;
    launch(ONE, ONE_P5, 1'b0);
    wait_done(lat, bb);
    checks++; if (lat != L_SP) begin failures++; $display("FAIL sp latency: got %0d want %0d", lat, L_SP); end
    checks++; if (bb) begin failures++; $display("FAIL sp busy window: got bad=1 want 0"); end
    checks++; if (bus.fq !== Q_SP) begin failures++; $display("FAIL sp 1.0/1.5 fq: got %h want %h", bus.fq, Q_SP); end
  endtask

  task automatic test_invalid();
    int lat;
    bit bb;
    launch(ONE, '0, 1'b1);
    wait_done(lat, bb);
    checks++; if (lat != 1) begin failures++; $display("FAIL inv latency: got %0d want 1", lat); end
    checks++; if (bus.inv !== 1'b1) begin failures++; $display("FAIL inv flag: got %b want 1", bus.inv); end
    checks++; if (bus.fq !== {FW{1'b1}}) begin failures++; $display("FAIL inv fq: got %h want all ones", bus.fq); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.inv !== 1'b1 || bus.fq !== {FW{1'b1}}) begin
      failures++; $display("FAIL inv hold: inv=%b fq=%h want 1/all ones", bus.inv, bus.fq);
    end
    launch(ONE_P5, 53'h0FFFFFFFFFFFFF, 1'b0);
    wait_done(lat, bb);
    checks++; if (lat != 1 || bus.inv !== 1'b1) begin
      failures++; $display("FAIL inv unnormalized fb: lat=%0d inv=%b want 1/1", lat, bus.inv);
    end
    launch('0, ONE, 1'b1);
    wait_done(lat, bb);
    checks++; if (bus.fq !== '0 || bus.inv !== 1'b0) begin
      failures++; $display("FAIL zero dividend: fq=%h inv=%b want 0/0", bus.fq, bus.inv);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    int done_at = 0;
    launch(ONE_P5, ONE, 1'b1);
    for (int e = 1; e <= L_DP + 10; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        bus.fa = ONE;
        bus.fb = ONE_P5;
        bus.db = 1'b0;
        bus.start = 1'b1;
      end else bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        done_at = e;
      end
    end
    checks++; if (ndone != 1) begin failures++; $display("FAIL busy ignore done count: got %0d want 1", ndone); end
    checks++; if (done_at != L_DP) begin failures++; $display("FAIL busy ignore done edge: got %0d want %0d", done_at, L_DP); end
    checks++; if (bus.fq !== Q_15_10) begin failures++; $display("FAIL busy ignore fq: got %h want %h", bus.fq, Q_15_10); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bb;
    launch(ONE_P5, ONE, 1'b1);
    wait_done(lat, bb);
    checks++; if (bus.fq !== Q_15_10) begin failures++; $display("FAIL b2b first fq: got %h want %h", bus.fq, Q_15_10); end
    launch(ONE, ONE_P5, 1'b0);
    wait_done(lat, bb);
    checks++; if (lat != L_SP) begin failures++; $display("FAIL b2b second latency: got %0d want %0d", lat, L_SP); end
    checks++; if (bus.fq !== Q_SP) begin failures++; $display("FAIL b2b second fq: got %h want %h", bus.fq, Q_SP); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int ndone = 0;
    bit bb;
    launch(ONE, ONE_P5, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.inv !== 1'b0 || bus.fq !== '0) begin
      failures++;
      $display("FAIL mid reset outputs: busy=%b done=%b inv=%b fq=%h want all 0", bus.busy, bus.done, bus.inv, bus.fq);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < L_DP + 10; e++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL mid reset stray done: got %0d want 0", ndone); end
    launch(ONE_P5, ONE, 1'b1);
    wait_done(lat, bb);
    checks++; if (lat != L_DP || bus.fq !== Q_15_10) begin
      failures++; $display("FAIL after reset op: lat=%0d fq=%h want %0d/%h", lat, bus.fq, L_DP, Q_15_10);
    end
  endtask

  task automatic test_random(input int n);
    int lat;
    bit bb;
    logic [MW-1:0] a, b;
    logic d;
    logic [FW-1:0] exp_fq;
    for (int i = 0; i < n; i++) begin
      d = 1'($urandom_range(0, 1));
      b = {1'b1, rnd_sig()} >> 1;
      b[MW-1] = 1'b1;
      a = rnd_sig();
      a[MW-1] = 1'b1;
      case ($urandom_range(0, 9))
        0: a = b;
        1: a = '1;
        2: a = rnd_sig() >> $urandom_range(1, 40);
        3: b = '1;
        4: b = ONE;
        default: ;
      endcase
      exp_fq = ref_fq(a, b, d);
      launch(a, b, d);
      wait_done(lat, bb);
      checks++; if (bus.fq !== exp_fq) begin
        failures++; $display("FAIL random fq db=%b fa=%h fb=%h: got %h want %h", d, a, b, bus.fq, exp_fq);
      end
      checks++; if (lat != (d ? L_DP : L_SP) || bb) begin
        failures++; $display("FAIL random timing db=%b: lat=%0d busy_bad=%b want %0d/0", d, lat, bb, d ? L_DP : L_SP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_sp();
    test_invalid();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random(1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
